// File: rtl/dmem_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_scan_arbiter_if
// Description : Bundle of the processor data port, the dmem port and the
//               scan-stream outputs around dmem_scan_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_scan_arbiter_if;
  logic        proc_req;
  logic [11:0] proc_addr;
  logic [31:0] proc_data;
  logic        proc_wren;
  logic [31:0] proc_q;
  logic        proc_stall;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        scan_enable;
  logic [31:0] scan_data;
  logic [7:0]  scan_index;
  logic        scan_valid;
  logic        frame_done;
  logic        busy;

  // Arbiter side
  modport slave (
    input  proc_req, proc_addr, proc_data, proc_wren, mem_q, scan_enable,
    output proc_q, proc_stall, mem_address, mem_data, mem_wren,
           scan_data, scan_index, scan_valid, frame_done, busy
  );

  // Environment side (processor, dmem, display logic)
  modport master (
    output proc_req, proc_addr, proc_data, proc_wren, mem_q, scan_enable,
    input  proc_q, proc_stall, mem_address, mem_data, mem_wren,
           scan_data, scan_index, scan_valid, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_scan_arbiter
// Description : Shares the single-port dmem between the processor data port
//               and a periodic framebuffer scan engine. The processor wins
//               by default; after MAX_WAIT denied cycles the scanner is
//               forced onto the bus for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_scan_arbiter #(
  parameter logic [11:0] BASE_ADDR   = 12'd3072,
  parameter int          NUM_WORDS   = 16,
  parameter int          SCAN_PERIOD = 1000,
  parameter int          MAX_WAIT    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_scan_arbiter_if.slave   bus
);

  localparam int c_PCNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [c_PCNT_W-1:0] c_PERIOD_LAST = c_PCNT_W'(SCAN_PERIOD - 1);
  localparam logic [c_WAIT_W-1:0] c_MAX_WAIT    = c_WAIT_W'(MAX_WAIT);
  localparam logic [7:0]          c_LAST_WORD   = 8'(NUM_WORDS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]          r_state;
  logic [c_PCNT_W-1:0] r_period_cnt;
  logic [7:0]          r_word_idx;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [31:0]         r_scan_data;
  logic [7:0]          r_scan_index;
  logic                r_scan_valid;
  logic                r_frame_done;

  logic w_in_scan;
  logic w_scan_grant;
  logic w_period_wrap;
  logic w_last_word;

  assign w_in_scan     = (r_state == S_SCAN);
  assign w_scan_grant  = w_in_scan & (~bus.proc_req | (r_wait_cnt == c_MAX_WAIT));
  assign w_period_wrap = bus.scan_enable & (r_period_cnt == c_PERIOD_LAST);
  assign w_last_word   = (r_word_idx == c_LAST_WORD);

  // Bus mux: the scanner only ever reads; store data always comes from the processor
  always_comb begin
    bus.mem_data = bus.proc_data;
    if (w_scan_grant) begin
      bus.mem_address = BASE_ADDR + {4'b0000, r_word_idx};
      bus.mem_wren    = 1'b0;
    end else begin
      bus.mem_address = bus.proc_addr;
      bus.mem_wren    = bus.proc_req & bus.proc_wren;
    end
  end

  assign bus.proc_q     = bus.mem_q;
  assign bus.proc_stall = bus.proc_req & w_scan_grant;
  assign bus.busy       = w_in_scan;
  assign bus.scan_data  = r_scan_data;
  assign bus.scan_index = r_scan_index;
  assign bus.scan_valid = r_scan_valid;
  assign bus.frame_done = r_frame_done;

  // Free-running frame period counter, parked at zero while scanning is disabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period_cnt <= '0;
    end else if (!bus.scan_enable || w_period_wrap) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + c_PCNT_W'(1);
    end
  end

  // Frame sequencing: start on period wrap, step per granted word, abort on disable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_period_wrap) begin
            r_state    <= S_SCAN;
            r_word_idx <= '0;
            r_wait_cnt <= '0;
          end
        end
        S_SCAN: begin
          if (w_scan_grant) begin
            r_wait_cnt <= '0;
            if (w_last_word) begin
              r_state    <= S_IDLE;
              r_word_idx <= '0;
            end else begin
              r_word_idx <= r_word_idx + 8'd1;
            end
          end else if (bus.proc_req && (r_wait_cnt != c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
          // A wrap seen here is an overrun and is simply dropped
          if (!bus.scan_enable) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_word_idx <= '0;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Capture the word read on a granted cycle; even an aborting cycle still delivers it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scan_data  <= '0;
      r_scan_index <= '0;
      r_scan_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_scan_valid <= w_scan_grant;
      r_frame_done <= w_scan_grant & w_last_word;
      if (w_scan_grant) begin
        r_scan_data  <= bus.mem_q;
        r_scan_index <= r_word_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_scan_arbiter
// Description : Randomized and directed bench for dmem_scan_arbiter with a
//               cycle-level reference model and a behavioural dmem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_scan_arbiter;

  localparam int c_BASE = 3072;
  localparam int c_N    = 16;
  localparam int c_P    = 40;
  localparam int c_MW   = 8;

  logic clock;
  logic reset;
  dmem_scan_arbiter_if bus_if ();

  dmem_scan_arbiter #(
    .BASE_ADDR   (12'd3072),
    .NUM_WORDS   (c_N),
    .SCAN_PERIOD (c_P),
    .MAX_WAIT    (c_MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // dmem is written on the falling edge and read combinationally
  logic [31:0] dmem    [4096];
  logic [31:0] ref_mem [4096];
  assign bus_if.mem_q = dmem[bus_if.mem_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_scan;
  int m_idx, m_wait, m_pcnt;
  bit m_valid, m_done;
  logic [31:0] m_sdata;
  int m_sidx;

  // observations from the latest step
  logic obs_stall, obs_busy_c, obs_valid, obs_done, obs_busy;
  logic [31:0] obs_q, obs_sdata;
  logic [7:0]  obs_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_idx = 0; m_wait = 0; m_pcnt = 0;
    m_valid = 0; m_done = 0; m_sdata = '0; m_sidx = 0;
  endtask

  task automatic drive(input bit req, input bit wren, input logic [11:0] addr,
                       input logic [31:0] data, input bit en);
    bus_if.proc_req    = req;
    bus_if.proc_wren   = wren;
    bus_if.proc_addr   = addr;
    bus_if.proc_data   = data;
    bus_if.scan_enable = en;
  endtask

  // One clock cycle; called 1 time unit after a rising edge with inputs set
  task automatic step();
    bit sg, ewren, req, en;
    int eaddr;
    logic [31:0] rd;
    req = bus_if.proc_req;
    en  = bus_if.scan_enable;
    sg    = m_scan && (!req || m_wait == c_MW);
    eaddr = sg ? (c_BASE + m_idx) % 4096 : int'(bus_if.proc_addr);
    ewren = !sg && req && bus_if.proc_wren;
    #1;
    obs_stall  = bus_if.proc_stall;
    obs_busy_c = bus_if.busy;
    obs_q      = bus_if.proc_q;
    check("proc_stall", bus_if.proc_stall, 32'(req && sg));
    check("mem_address", bus_if.mem_address, 32'(eaddr));
    check("mem_wren", bus_if.mem_wren, 32'(ewren));
    check("mem_data", bus_if.mem_data, bus_if.proc_data);
    check("proc_q", bus_if.proc_q, ref_mem[eaddr]);
    check("busy_comb", bus_if.busy, 32'(m_scan));
    rd = ref_mem[(c_BASE + m_idx) % 4096];
    @(negedge clock);
    if (bus_if.mem_wren) dmem[bus_if.mem_address] = bus_if.mem_data;
    if (ewren) ref_mem[bus_if.proc_addr] = bus_if.proc_data;
    @(posedge clock);
    // reference model: next-cycle behaviour from the arbitration rules
    m_valid = sg;
    m_done  = sg && (m_idx == c_N - 1);
    if (sg) begin m_sdata = rd; m_sidx = m_idx; end
    if (m_scan) begin
      if (sg) begin
        m_wait = 0;
        if (m_idx == c_N - 1) begin m_scan = 0; m_idx = 0; end
        else m_idx++;
      end else if (req && m_wait < c_MW) m_wait++;
      if (!en) begin m_scan = 0; m_idx = 0; m_wait = 0; end
    end else if (en && m_pcnt == c_P - 1) begin
      m_scan = 1; m_idx = 0; m_wait = 0;
    end
    m_pcnt = !en ? 0 : (m_pcnt == c_P - 1 ? 0 : m_pcnt + 1);
    #1;
    obs_valid = bus_if.scan_valid;
    obs_done  = bus_if.frame_done;
    obs_idx   = bus_if.scan_index;
    obs_sdata = bus_if.scan_data;
    obs_busy  = bus_if.busy;
    check("scan_valid", bus_if.scan_valid, 32'(m_valid));
    check("frame_done", bus_if.frame_done, 32'(m_done));
    check("scan_data", bus_if.scan_data, m_sdata);
    check("scan_index", bus_if.scan_index, 32'(m_sidx));
    check("busy", bus_if.busy, 32'(m_scan));
  endtask

  initial begin
    int dones, busy_cnt, stall_cnt, last_done, last_valid, cyc, steps;
    bit have_prev, found;
    logic [31:0] v;
    bit en;

    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      dmem[i] = v; ref_mem[i] = v;
    end
    for (int i = 0; i < c_N; i++) begin
      dmem[c_BASE + i] = 32'hA0 + 32'(i); ref_mem[c_BASE + i] = 32'hA0 + 32'(i);
    end

    // reset held low
    reset = 1'b0;
    drive(0, 0, 12'd0, 32'd0, 0);
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", bus_if.busy, 0);
    check("rst_valid", bus_if.scan_valid, 0);
    check("rst_done", bus_if.frame_done, 0);
    check("rst_index", bus_if.scan_index, 0);
    check("rst_data", bus_if.scan_data, 0);
    reset = 1'b1;

    // idle: addresses pass straight through
    for (int k = 0; k < 2000; k++) begin
      drive(0, 0, 12'($urandom), $urandom, 0);
      step();
    end

    // uncontested frames
    dones = 0; busy_cnt = 0; last_done = 0; cyc = 0;
    for (int k = 0; k < 300 && dones < 3; k++) begin
      drive(0, 0, 12'($urandom), $urandom, 1);
      step();
      cyc++;
      if (obs_busy_c) busy_cnt++;
      if (obs_valid) check("fb_word", obs_sdata, 32'hA0 + 32'(obs_idx));
      if (obs_done) begin
        dones++;
        check("frame_busy_cycles", busy_cnt, c_N);
        if (dones > 1) check("frame_spacing", cyc - last_done, c_P);
        last_done = cyc; busy_cnt = 0;
      end
    end
    check("uncontested_frames", dones, 3);

    // processor hammers dmem with loads: scanner forced in once per MAX_WAIT+1
    dones = 0; stall_cnt = 0; have_prev = 0; last_valid = 0; cyc = 0;
    for (int k = 0; k < 1000 && dones < 2; k++) begin
      drive(1, 0, 12'($urandom), $urandom, 1);
      step();
      cyc++;
      if (obs_stall) stall_cnt++;
      if (obs_valid) begin
        if (have_prev) check("word_gap", cyc - last_valid, c_MW + 1);
        have_prev = 1; last_valid = cyc;
      end
      if (obs_done) begin
        dones++;
        check("stalls_per_frame", stall_cnt, c_N);
        stall_cnt = 0; have_prev = 0;
      end
    end
    check("contested_frames", dones, 2);

    // store passthrough then load back
    drive(1, 1, 12'd100, 32'hDEADBEEF, 0);
    step();
    drive(1, 0, 12'd100, 32'h0, 0);
    step();
    check("load_back", obs_q, 32'hDEADBEEF);

    // abort mid-frame after word 5, then restart from index 0
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      drive(0, 0, 12'($urandom), $urandom, 1);
      step();
      found = obs_valid && obs_idx == 8'd5;
    end
    check("abort_reach_word5", 32'(found), 1);
    drive(0, 0, 12'd0, 32'd0, 0);
    step();
    check("abort_busy", obs_busy, 0);
    check("abort_no_done", obs_done, 0);
    repeat (5) step();
    found = 0; steps = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      drive(0, 0, 12'($urandom), $urandom, 1);
      step();
      steps++;
      found = obs_valid;
    end
    check("restart_found", 32'(found), 1);
    check("restart_index", obs_idx, 0);
    check("restart_latency", steps, c_P + 1);

    // asynchronous reset between edges while scanning
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      found = obs_valid && obs_idx == 8'd1;
    end
    check("areset_reach_word1", 32'(found), 1);
    #2 reset = 1'b0;
    #1;
    check("areset_busy", bus_if.busy, 0);
    check("areset_valid", bus_if.scan_valid, 0);
    check("areset_index", bus_if.scan_index, 0);
    check("areset_data", bus_if.scan_data, 0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    found = 0; steps = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      steps++;
      found = obs_valid;
    end
    check("post_reset_latency", steps, c_P + 1);

    // randomized traffic with occasional scan disable
    en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      drive(($urandom % 4) != 0, ($urandom % 3) == 0, 12'($urandom), $urandom, en);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_scan_arbiter.md
Name: dmem_scan_arbiter

Overview:
- Shares the single-port dmem between the processor data port and an internal screen-scan engine.
- The scan engine periodically reads a framebuffer region of dmem and streams it word-by-word to the display/MMIO logic.
- The processor has priority. A bounded-wait rule guarantees that the scanner makes progress.
- Sits between processor_alt's dmem port and the dmem syncram. dmem returns read data within the same clock cycle, because it is clocked on ~clock.

Parameters:
- BASE_ADDR, 12'd3072: first dmem word of the framebuffer.
- NUM_WORDS, 16: words per frame, range 1..256.
- SCAN_PERIOD, 1000: clock cycles between frame triggers, at least NUM_WORDS+MAX_WAIT.
- MAX_WAIT, 8: maximum consecutive denied cycles before the scanner is forced onto the bus, at least 1.

Ports:
- clock, in, 1: master clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- proc_req, in, 1: processor drives a dmem access this cycle (load or store).
- proc_addr, in, 12: processor dmem address.
- proc_data, in, 32: processor store data.
- proc_wren, in, 1: processor store enable, qualified by proc_req.
- proc_q, out, 32: load data to the processor.
- proc_stall, out, 1: processor access not serviced this cycle; the processor must hold its request.
- mem_address, out, 12: to dmem address.
- mem_data, out, 32: to dmem data.
- mem_wren, out, 1: to dmem wren.
- mem_q, in, 32: from dmem q.
- scan_enable, in, 1: enables periodic frame scanning.
- scan_data, out, 32: last framebuffer word read.
- scan_index, out, 8: word index of scan_data.
- scan_valid, out, 1: one-cycle pulse when scan_data/scan_index update.
- frame_done, out, 1: one-cycle pulse, coincident with scan_valid for the last word.
- busy, out, 1: high while in state SCAN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; period_cnt, word_idx and wait_cnt = 0.
  - scan_data=0, scan_index=0, scan_valid=0, frame_done=0, busy=0.
  - Combinational outputs follow the IDLE rules below.
- States: IDLE and SCAN.
- period_cnt:
  - While scan_enable=1 it counts 0..SCAN_PERIOD-1 and wraps.
  - While scan_enable=0 it is held at 0.
- IDLE -> SCAN when period_cnt==SCAN_PERIOD-1 and scan_enable=1; this also loads word_idx=0 and wait_cnt=0.
- Frame overrun: a wrap that occurs while already in SCAN is dropped, with no queueing.
- Grant rule, combinational, evaluated every cycle:
  - scan_grant = (state==SCAN) & (~proc_req | wait_cnt==MAX_WAIT).
  - proc_grant = proc_req & ~scan_grant.
  - proc_stall = proc_req & scan_grant.
- Memory muxing:
  - On scan_grant: mem_address=BASE_ADDR+word_idx (mod 4096), mem_wren=0, mem_data=proc_data.
  - Otherwise: mem_address=proc_addr, mem_data=proc_data, mem_wren=proc_req & proc_wren.
  - proc_q = mem_q at all times. The processor ignores proc_q while stalled.
- wait_cnt in SCAN:
  - +1 (saturating at MAX_WAIT) on each cycle with proc_req=1 and no scan_grant.
  - Cleared to 0 on every scan_grant.
  - Latency bound: the scanner waits at most MAX_WAIT cycles per word; the processor is stalled at most 1 cycle in every MAX_WAIT+1.
- On the edge ending a scan_grant cycle:
  - scan_data<=mem_q, scan_index<=word_idx, scan_valid<=1.
  - If word_idx==NUM_WORDS-1: frame_done<=1, state<=IDLE, word_idx<=0.
  - Otherwise: word_idx<=word_idx+1.
- scan_valid and frame_done are 0 on every other edge, so they are single-cycle pulses.
- Uncontested frame duration: exactly NUM_WORDS cycles.
- busy = (state==SCAN).
- scan_enable falling while in SCAN: abort at the next edge. state<=IDLE, word_idx<=0, wait_cnt<=0, no frame_done. scan_data and scan_index keep their last values.
- A read issued during a scan_grant cycle in which scan_enable falls still completes: the scan_valid update for that word occurs.
- A processor store is never merged with or reordered against a scan read. A scanner read in the same cycle as a stalled store sees pre-store data.

Test Plan:
- Reset then idle: hold reset=0, then release with scan_enable=0, proc_req=0 for 2000 cycles -> busy=0, scan_valid never 1, mem_wren=0, mem_address tracks proc_addr.
- Uncontested frame: SCAN_PERIOD=40, NUM_WORDS=4, dmem[3072..3075]=0xA0..0xA3, scan_enable=1, proc_req=0 -> busy high 4 cycles; scan_valid pulses with index 0..3 and data 0xA0..0xA3; frame_done with index 3; the next frame starts 40 cycles after the first.
- Processor priority and forced grant: MAX_WAIT=8, proc_req held 1 (loads) throughout SCAN -> proc_stall=1 on exactly 1 cycle per 9; each word arrives on the 9th cycle after the previous grant; proc_q equals dmem[proc_addr] on every non-stall cycle.
- Store passthrough: in IDLE, proc_req=1, proc_wren=1, proc_addr=100, proc_data=0xDEADBEEF -> mem_wren=1, mem_address=100 in the same cycle; a later processor load of 100 returns 0xDEADBEEF.
- Abort mid-frame: NUM_WORDS=16, drop scan_enable after word index 5 -> busy low next cycle, no frame_done, period_cnt=0; on re-enable, the next frame restarts at index 0.
- Async reset mid-SCAN: assert reset low between clock edges during word 2 -> busy, scan_valid and scan_index go to 0 immediately without a clock edge; after release, the block behaves as after a fresh reset.
